// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : common                                                  |
// | Purpose  : ibus/dbus request/response types and arbiter FSM state  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

  localparam logic [63:0] c_err_data  = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [2:0]  c_ibus_size = 3'b010;

  // An instruction fetch returns the 32-bit half selected by address bit 2.
  function automatic logic [31:0] ibus_word(input logic [63:0] beat, input logic sel_hi);
    return sel_hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : arb_pick                                                |
// | Purpose  : ibus/dbus winner selection with last-winner memory      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module arb_pick #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic ivalid,
  input  logic dvalid,
  output logic pick_i,
  output logic pick_d
);

  logic r_last_d;

  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (grant_en) begin
      if (ivalid && dvalid) begin
        if ((ROUND_ROBIN != 0) && r_last_d) pick_i = 1'b1;
        else                                pick_d = 1'b1;
      end else if (dvalid) begin
        pick_d = 1'b1;
      end else if (ivalid) begin
        pick_i = 1'b1;
      end
    end
  end

  // Resets to "ibus won last" so dbus takes the first contested grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_last_d <= 1'b0;
    else if (pick_d) r_last_d <= 1'b1;
    else if (pick_i) r_last_d <= 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bus_arbiter                                             |
// | Purpose  : single-outstanding ibus/dbus to memory arbiter          |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module bus_arbiter
  import common::*;
#(
  parameter int ROUND_ROBIN = 0,
  parameter int MAX_WAIT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        mreq_valid,
  output logic        mreq_write,
  output logic [2:0]  mreq_size,
  output logic [63:0] mreq_addr,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mresp_ready,
  input  logic [63:0] mresp_data
);

  localparam int WAIT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MAX_WAIT - 1);

  arb_state_t        r_state;
  logic [63:0]       r_addr;
  logic [2:0]        r_size;
  logic [7:0]        r_strobe;
  logic [63:0]       r_wdata;
  logic              r_write;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_err;
  logic              r_i_data_ok;
  logic [31:0]       r_i_data;
  logic              r_d_data_ok;
  logic [63:0]       r_d_data;

  logic              w_grant_en;
  logic              w_pick_i;
  logic              w_pick_d;
  logic              w_done;
  logic [63:0]       w_beat;

  // Reset gates the grant so addr_ok stays low even with requests held.
  assign w_grant_en = (r_state == IDLE) && rst;
  assign w_done     = mresp_ready || (r_cnt == c_wait_last);
  assign w_beat     = mresp_ready ? mresp_data : c_err_data;

  arb_pick #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .grant_en (w_grant_en),
    .ivalid   (ireq.valid),
    .dvalid   (dreq.valid),
    .pick_i   (w_pick_i),
    .pick_d   (w_pick_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_size      <= '0;
      r_strobe    <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_i_data_ok <= 1'b0;
      r_i_data    <= '0;
      r_d_data_ok <= 1'b0;
      r_d_data    <= '0;
    end else begin
      r_i_data_ok <= 1'b0;
      r_d_data_ok <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pick_d) begin
            r_addr   <= dreq.addr;
            r_size   <= dreq.size;
            r_strobe <= dreq.strobe;
            r_wdata  <= dreq.data;
            r_write  <= |dreq.strobe;
            r_state  <= GRANT_D;
          end else if (w_pick_i) begin
            r_addr   <= ireq.addr & ~64'h3;
            r_size   <= c_ibus_size;
            r_strobe <= '0;
            r_wdata  <= '0;
            r_write  <= 1'b0;
            r_state  <= GRANT_I;
          end
        end
        GRANT_I, GRANT_D: begin
          if (w_done) begin
            r_err <= r_err | ~mresp_ready;
            if (r_state == GRANT_I) begin
              r_i_data_ok <= 1'b1;
              r_i_data    <= ibus_word(w_beat, r_addr[2]);
              r_state     <= RESP_I;
            end else begin
              r_d_data_ok <= 1'b1;
              r_d_data    <= (r_write && mresp_ready) ? 64'h0 : w_beat;
              r_state     <= RESP_D;
            end
          end else begin
            r_cnt <= r_cnt + WAIT_W'(1);
          end
        end
        RESP_I, RESP_D: begin
          r_i_data <= '0;
          r_d_data <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign iresp.addr_ok = w_pick_i;
  assign iresp.data_ok = r_i_data_ok;
  assign iresp.data    = r_i_data;
  assign dresp.addr_ok = w_pick_d;
  assign dresp.data_ok = r_d_data_ok;
  assign dresp.data    = r_d_data;

  assign mreq_valid  = (r_state == GRANT_I) || (r_state == GRANT_D);
  assign mreq_write  = r_write;
  assign mreq_size   = r_size;
  assign mreq_addr   = r_addr;
  assign mreq_strobe = r_strobe;
  assign mreq_data   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_bus_arbiter                                          |
// | Purpose  : scoreboard bench for bus_arbiter (fixed and RR configs) |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_bus_arbiter;
  import common::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  ibus_req_t  ireq_a, ireq_b;
  dbus_req_t  dreq_a, dreq_b;
  ibus_resp_t iresp_a, iresp_b;
  dbus_resp_t dresp_a, dresp_b;
  logic        mv_a, mw_a, mv_b, mw_b;
  logic [2:0]  ms_a, ms_b;
  logic [63:0] ma_a, md_a, ma_b, md_b;
  logic [7:0]  mst_a, mst_b;
  logic        mr_a = 1'b0, mr_b = 1'b0;
  logic [63:0] mrd_a = '0, mrd_b = '0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_d;
    logic [63:0] data;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  bus_arbiter #(.ROUND_ROBIN(0), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst), .ireq(ireq_a), .iresp(iresp_a), .dreq(dreq_a), .dresp(dresp_a),
    .mreq_valid(mv_a), .mreq_write(mw_a), .mreq_size(ms_a), .mreq_addr(ma_a),
    .mreq_strobe(mst_a), .mreq_data(md_a), .mresp_ready(mr_a), .mresp_data(mrd_a)
  );

  bus_arbiter #(.ROUND_ROBIN(1), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst(rst), .ireq(ireq_b), .iresp(iresp_b), .dreq(dreq_b), .dresp(dresp_b),
    .mreq_valid(mv_b), .mreq_write(mw_b), .mreq_size(ms_b), .mreq_addr(ma_b),
    .mreq_strobe(mst_b), .mreq_data(md_b), .mresp_ready(mr_b), .mresp_data(mrd_b)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop one expected response per data_ok.
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (iresp_a.data_ok || dresp_a.data_ok)) begin
        chk("a_data_ok_exclusive", iresp_a.data_ok & dresp_a.data_ok, 0);
        chk("a_addr_ok_with_data_ok", iresp_a.addr_ok | dresp_a.addr_ok, 0);
        if (q_a.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_unexpected_resp: got data_ok, expected none");
        end else begin
          e = q_a.pop_front();
          chk("a_resp_port", dresp_a.data_ok, e.is_d);
          chk("a_resp_data", e.is_d ? dresp_a.data : {32'h0, iresp_a.data}, e.data);
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (iresp_b.data_ok || dresp_b.data_ok)) begin
        chk("b_data_ok_exclusive", iresp_b.data_ok & dresp_b.data_ok, 0);
        if (q_b.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_unexpected_resp: got data_ok, expected none");
        end else begin
          e = q_b.pop_front();
          chk("b_resp_port", dresp_b.data_ok, e.is_d);
          chk("b_resp_data", e.is_d ? dresp_b.data : {32'h0, iresp_b.data}, e.data);
        end
      end
    end
  end

  // Memory for dut_b answers in the first grant cycle with the address echoed.
  initial begin : mem_b
    forever begin
      @(posedge clk); #1;
      mr_b  = mv_b;
      mrd_b = mv_b ? {ma_b[31:0], ma_b[31:0]} : 64'h0;
    end
  end

  // Entered at #1 in the IDLE cycle with the request already presented.
  task automatic txn_a(input bit is_d, input logic [63:0] m_addr, input bit m_write,
                       input logic [2:0] m_size, input logic [7:0] m_strb, input logic [63:0] m_wdata,
                       input int waits, input logic [63:0] rdata, input logic [63:0] exp_data,
                       input bit early);
    int   n_grant;
    exp_t e;
    n_grant = (waits < 0) ? 4 : waits + 1;
    @(negedge clk);
    chk("a_addr_ok_winner", is_d ? dresp_a.addr_ok : iresp_a.addr_ok, 1);
    chk("a_addr_ok_loser",  is_d ? iresp_a.addr_ok : dresp_a.addr_ok, 0);
    e.is_d = is_d;
    e.data = exp_data;
    q_a.push_back(e);
    @(posedge clk); #1;
    if (early) begin
      if (is_d) begin
        dreq_a.valid = 1'b0; dreq_a.addr = ~dreq_a.addr; dreq_a.data = ~dreq_a.data;
      end else begin
        ireq_a.valid = 1'b0; ireq_a.addr = ~ireq_a.addr;
      end
    end
    for (int k = 0; k < n_grant; k++) begin
      if (k == waits) begin
        mr_a  = 1'b1;
        mrd_a = rdata;
      end
      @(negedge clk);
      chk("a_mreq_valid", mv_a, 1);
      chk("a_mreq_fields", {mw_a, ms_a, mst_a, ma_a, md_a}, {m_write, m_size, m_strb, m_addr, m_wdata});
      chk("a_no_data_ok_in_grant", iresp_a.data_ok | dresp_a.data_ok, 0);
      @(posedge clk); #1;
    end
    mr_a  = 1'b0;
    mrd_a = '0;
    @(negedge clk);
    chk("a_data_ok_timing", is_d ? dresp_a.data_ok : iresp_a.data_ok, 1);
    chk("a_mreq_valid_drop", mv_a, 0);
    chk("a_no_grant_in_resp", iresp_a.addr_ok | dresp_a.addr_ok, 0);
    if (is_d) dreq_a.valid = 1'b0;
    else      ireq_a.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : main
    exp_t e;
    int   nb;
    rst    = 1'b0;
    ireq_a = '0; dreq_a = '0; ireq_b = '0; dreq_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_iresp", iresp_a, 0);
    chk("rst_dresp", dresp_a, 0);
    chk("rst_mreq", {mv_a, mw_a, ms_a, mst_a, ma_a, md_a}, 0);
    chk("rst_err", dut_a.r_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ibus fetch, upper word, ready after two grant cycles
    ireq_a = '{valid: 1'b1, addr: 64'h8000_0004};
    txn_a(0, 64'h8000_0004, 0, 3'b010, 8'h00, 64'h0, 1, 64'h1111_1111_2222_2222, 64'h1111_1111, 0);

    // unaligned ibus address is word-aligned, lower word returned
    ireq_a = '{valid: 1'b1, addr: 64'h100B};
    txn_a(0, 64'h1008, 0, 3'b010, 8'h00, 64'h0, 0, 64'hCAFE_F00D_1234_5678, 64'h1234_5678, 0);

    // simultaneous requests, fixed priority: dbus then ibus
    dreq_a = '{valid: 1'b1, addr: 64'h2000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    ireq_a = '{valid: 1'b1, addr: 64'h3004};
    txn_a(1, 64'h2000, 0, 3'd3, 8'h00, 64'h0, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0);
    txn_a(0, 64'h3004, 0, 3'b010, 8'h00, 64'h0, 2, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98, 0);

    // dbus write returns zero data
    dreq_a = '{valid: 1'b1, addr: 64'h5000, size: 3'd3, strobe: 8'h0F, data: 64'hAABB};
    txn_a(1, 64'h5000, 1, 3'd3, 8'h0F, 64'hAABB, 1, 64'h1234_5678_9ABC_DEF0, 64'h0, 0);

    // request withdrawn and altered while granted still completes from latched fields
    dreq_a = '{valid: 1'b1, addr: 64'h7010, size: 3'd2, strobe: 8'h00, data: 64'h55};
    txn_a(1, 64'h7010, 0, 3'd2, 8'h00, 64'h55, 1, 64'h0BAD_CAFE_0000_0001, 64'h0BAD_CAFE_0000_0001, 1);

    // memory never answers: error data after MAX_WAIT grant cycles
    chk("err_clear_before_timeout", dut_a.r_err, 0);
    dreq_a = '{valid: 1'b1, addr: 64'h4000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    txn_a(1, 64'h4000, 0, 3'd3, 8'h00, 64'h0, -1, 64'h0, 64'hDEAD_BEEF_DEAD_BEEF, 0);
    chk("err_set_after_timeout", dut_a.r_err, 1);
    ireq_a = '{valid: 1'b1, addr: 64'h9000};
    txn_a(0, 64'h9000, 0, 3'b010, 8'h00, 64'h0, 0, 64'h0000_0002_0000_0001, 64'h1, 0);
    chk("err_sticky", dut_a.r_err, 1);

    // reset during GRANT_D abandons the transaction; the held request is reissued
    dreq_a = '{valid: 1'b1, addr: 64'h6000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    @(negedge clk);
    chk("rstmid_addr_ok", dresp_a.addr_ok, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_granted", mv_a, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_async_mreq_valid", mv_a, 0);
    chk("rstmid_err_cleared", dut_a.r_err, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_no_data_ok", dresp_a.data_ok, 0);
    chk("rstmid_no_addr_ok", dresp_a.addr_ok, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    txn_a(1, 64'h6000, 0, 3'd3, 8'h00, 64'h0, 0, 64'h600D_600D_600D_600D, 64'h600D_600D_600D_600D, 0);

    // round robin with both ports held: D, I, D, I
    e.is_d = 1; e.data = 64'h0000_D000_0000_D000; q_b.push_back(e);
    e.is_d = 0; e.data = 64'h0000_1004;           q_b.push_back(e);
    e.is_d = 1; e.data = 64'h0000_D000_0000_D000; q_b.push_back(e);
    e.is_d = 0; e.data = 64'h0000_1004;           q_b.push_back(e);
    dreq_b = '{valid: 1'b1, addr: 64'hD000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    ireq_b = '{valid: 1'b1, addr: 64'h1004};
    nb = 0;
    for (int c = 0; c < 60 && nb < 4; c++) begin
      @(negedge clk);
      if (iresp_b.data_ok || dresp_b.data_ok) nb++;
    end
    ireq_b.valid = 1'b0;
    dreq_b.valid = 1'b0;
    chk("b_four_responses", nb, 4);

    repeat (4) @(posedge clk);
    #1;
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
